// File: rtl/cpu_program_sequencer_if.sv
// cpu_program_sequencer_if
//   Instruction handshake between the program sequencer and the cpu core.
//   The sequencer is the master: it presents an instruction and its immediate
//   data, pulses start for one cycle, and waits for the cpu to return done.
//   Signals:
//     start        sequencer -> cpu   one-cycle start pulse
//     instruction  sequencer -> cpu   9-bit instruction word
//     data_var     sequencer -> cpu   16-bit immediate data
//     done         cpu -> sequencer   current instruction finished
interface cpu_program_sequencer_if;
  logic        start;
  logic [8:0]  instruction;
  logic [15:0] data_var;
  logic        done;

  modport master (output start, output instruction, output data_var, input done);
  modport slave  (input start, input instruction, input data_var, output done);
endinterface

// File: rtl/cpu_program_sequencer.sv
// cpu_program_sequencer
//   Small program memory of {last, instruction, data} entries, loaded by a
//   host while idle. On run the entries are issued to the cpu in address order,
//   one at a time, waiting for done before moving on. The program stops on a
//   last-flagged entry, at the top address, on abort, or when done does not
//   arrive within TIMEOUT cycles.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     prog_we/addr/instr/data/last  program write port (dropped while busy)
//     run                           start program at address 0 (ignored while busy)
//     abort                         return to IDLE at once, highest priority
//     cpu                           instruction handshake, master side
//     pc                            address of the entry being issued
//     busy                          FETCH, ISSUE or WAIT
//     halted                        program finished normally (sticky)
//     timeout_err                   done never arrived (sticky)
//     instr_count                   completed instructions, saturating
//
//   state  | meaning
//   IDLE   | waiting for run
//   FETCH  | read mem[pc] into the cpu instruction/data registers
//   ISSUE  | cpu start pulse, arm the done timer
//   WAIT   | waiting for cpu done, timer counting down
//   HALTED | program completed normally
//   ERROR  | cpu done timed out
module cpu_program_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [8:0]            prog_instr,
  input  logic [15:0]           prog_data,
  input  logic                  prog_last,
  input  logic                  run,
  input  logic                  abort,
  cpu_program_sequencer_if.master cpu,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  timeout_err,
  output logic [15:0]           instr_count
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Loaded in ISSUE; reaching zero in WAIT marks the TIMEOUT-th WAIT cycle.
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    HALTED = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [25:0]       mem [DEPTH];
  logic [8:0]        instr_q;
  logic [15:0]       data_q;
  logic              last_q;
  logic [TMR_W-1:0]  tmr;
  logic              start_c;
  logic              prog_end;

  assign prog_end        = last_q || (pc == TOP_ADDR);
  assign cpu.instruction = instr_q;
  assign cpu.data_var    = data_q;
  assign cpu.start       = start_c;

  // Program memory: not reset, written only while the sequencer is not busy.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= {prog_last, prog_instr, prog_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, HALTED, ERROR: if (run) state_n = FETCH;
        FETCH:               state_n = ISSUE;
        ISSUE: begin
          if (cpu.done) state_n = prog_end ? HALTED : FETCH;
          else          state_n = WAIT;
        end
        WAIT: begin
          if (cpu.done)       state_n = prog_end ? HALTED : FETCH;
          else if (tmr == '0) state_n = ERROR;
        end
        default:             state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    start_c     = (state == ISSUE);
    busy        = (state == FETCH) || (state == ISSUE) || (state == WAIT);
    halted      = (state == HALTED);
    timeout_err = (state == ERROR);
  end

  // Datapath; abort freezes pc, count and the presented instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      instr_count <= '0;
      instr_q     <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      tmr         <= '0;
    end else if (!abort) begin
      unique case (state)
        IDLE, HALTED, ERROR: begin
          if (run) begin
            pc          <= '0;
            instr_count <= '0;
          end
        end
        FETCH: begin
          {last_q, instr_q, data_q} <= mem[pc];
        end
        ISSUE, WAIT: begin
          if (state == ISSUE) begin
            tmr <= TMR_LOAD;
          end else if (!cpu.done && tmr != '0) begin
            tmr <= tmr - 1'b1;
          end
          if (cpu.done) begin
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            if (!prog_end) pc <= pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
module tb_cpu_program_sequencer;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;

  logic              clk;
  logic              rst;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [8:0]        prog_instr;
  logic [15:0]       prog_data;
  logic              prog_last;
  logic              run;
  logic              abort;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              timeout_err;
  logic [15:0]       instr_count;

  cpu_program_sequencer_if cpu_if ();

  cpu_program_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_instr(prog_instr), .prog_data(prog_data), .prog_last(prog_last),
    .run(run), .abort(abort), .cpu(cpu_if), .pc(pc), .busy(busy),
    .halted(halted), .timeout_err(timeout_err), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [8:0]  instr;
    logic [15:0] data;
    int          pc;
  } exp_t;
  exp_t exp_q[$];

  logic [8:0]  p_instr [DEPTH];
  logic [15:0] p_data  [DEPTH];
  logic        p_last  [DEPTH];

  // cpu model and scoreboard consumer
  int   done_dly   = 3;
  bit   cpu_en     = 1'b1;
  bit   force_done = 1'b0;
  int   cnt        = 0;
  int   n_starts   = 0;
  int   last_start = -1;
  int   run_cyc    = 0;

  initial cpu_if.done = 1'b0;

  always @(negedge clk) begin
    logic mdl_done;
    exp_t e;
    mdl_done = 1'b0;
    if (cpu_if.start === 1'b1) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("start_instr", cpu_if.instruction, e.instr);
        chk("start_data", cpu_if.data_var, e.data);
        chk("start_pc", pc, e.pc);
      end
      if (last_start < 0) chk("run_to_start", cyc - run_cyc, 1);
      else                chk("start_gap", cyc - last_start, done_dly + 2);
      last_start = cyc;
      if (cpu_en) begin
        if (done_dly == 0) mdl_done = 1'b1;
        else               cnt = done_dly;
      end
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) mdl_done = 1'b1;
    end
    cpu_if.done = mdl_done | force_done;
  end

  task automatic write_entry(input int a, input logic [8:0] i, input logic [15:0] d, input logic l);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_instr = i; prog_data = d; prog_last = l;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_prog(input int last_at);
    for (int a = 0; a < DEPTH; a++) begin
      p_instr[a] = 9'($urandom);
      p_data[a]  = 16'($urandom);
      p_last[a]  = (a == last_at);
      write_entry(a, p_instr[a], p_data[a], p_last[a]);
    end
  endtask

  task automatic push_exp(input int upto);
    exp_t e;
    for (int a = 0; a <= upto; a++) begin
      e.instr = p_instr[a]; e.data = p_data[a]; e.pc = a;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    run = 1'b1; run_cyc = cyc + 1; last_start = -1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (k == max_cyc) chk({name, "_wait_timeout"}, 1, 0);
  endtask

  typedef struct {
    int last_at;
    int done_dly;
    int exp_count;
    int exp_pc;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int base, k;
    vecs[0] = '{last_at: 2,  done_dly: 3, exp_count: 3,  exp_pc: 2};
    vecs[1] = '{last_at: 0,  done_dly: 0, exp_count: 1,  exp_pc: 0};
    vecs[2] = '{last_at: -1, done_dly: 1, exp_count: 16, exp_pc: 15};
    vecs[3] = '{last_at: 4,  done_dly: 0, exp_count: 5,  exp_pc: 4};
    vecs[4] = '{last_at: 7,  done_dly: 2, exp_count: 8,  exp_pc: 7};

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_instr = '0; prog_data = '0;
    prog_last = 1'b0; run = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", cpu_if.start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_instr", cpu_if.instruction, 0);
    chk("rst_data", cpu_if.data_var, 0);
    rst = 1'b0;

    // table-driven programs
    for (int v = 0; v < 5; v++) begin
      done_dly = vecs[v].done_dly; cpu_en = 1'b1;
      load_prog(vecs[v].last_at);
      push_exp(vecs[v].exp_pc);
      start_run();
      wait_idle(2000, "vec");
      chk("vec_halted", halted, 1);
      chk("vec_timeout", timeout_err, 0);
      chk("vec_pc", pc, vecs[v].exp_pc);
      chk("vec_count", instr_count, vecs[v].exp_count);
      chk("vec_queue_left", exp_q.size(), 0);
    end

    // done timeout, then run clears the error and restarts at pc 0
    cpu_en = 1'b0; done_dly = 0;
    load_prog(0);
    push_exp(0);
    start_run();
    for (k = 0; k < 200; k++) begin
      if (timeout_err) break;
      @(negedge clk);
    end
    chk("timeout_seen", timeout_err, 1);
    chk("timeout_cycles", cyc - last_start, TIMEOUT + 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_count", instr_count, 0);
    cpu_en = 1'b1; done_dly = 1;
    push_exp(0);
    start_run();
    chk("rerun_clear_err", timeout_err, 0);
    chk("rerun_pc", pc, 0);
    chk("rerun_busy", busy, 1);
    wait_idle(200, "rerun");
    chk("rerun_halted", halted, 1);
    chk("rerun_count", instr_count, 1);

    // abort during WAIT of entry 1; busy-time run/prog_we have no effect
    cpu_en = 1'b1; done_dly = 10;
    load_prog(3);
    push_exp(1);
    base = n_starts;
    start_run();
    for (k = 0; k < 200; k++) begin
      if (n_starts >= base + 2) break;
      @(negedge clk);
    end
    chk("abort_reach_entry1", n_starts - base, 2);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd3; prog_instr = ~p_instr[3]; prog_data = ~p_data[3];
    prog_last = 1'b0; run = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; run = 1'b0;
    chk("busy_run_ignored_pc", pc, 1);
    chk("busy_run_still_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_start", cpu_if.start, 0);
    chk("abort_halted", halted, 0);
    chk("abort_timeout", timeout_err, 0);
    chk("abort_pc_hold", pc, 1);
    chk("abort_count_hold", instr_count, 1);
    chk("abort_instr_hold", cpu_if.instruction, p_instr[1]);
    chk("abort_data_hold", cpu_if.data_var, p_data[1]);
    base = n_starts;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort_no_start", n_starts - base, 0);
    chk("abort_done_ignored", instr_count, 1);
    chk("abort_still_idle", busy, 0);
    done_dly = 1;
    push_exp(3);
    start_run();
    wait_idle(200, "after_abort");
    chk("dropped_write_halted", halted, 1);
    chk("dropped_write_count", instr_count, 4);
    chk("dropped_write_queue", exp_q.size(), 0);

    // async reset between clock edges while in ISSUE
    done_dly = 2;
    load_prog(1);
    push_exp(0);
    base = n_starts;
    start_run();
    for (k = 0; k < 50; k++) begin
      if (cpu_if.start) break;
      @(negedge clk);
    end
    chk("arst_reach_issue", cpu_if.start, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_start", cpu_if.start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pc", pc, 0);
    chk("arst_count", instr_count, 0);
    chk("arst_instr", cpu_if.instruction, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("arst_no_more_start", n_starts - base, 1);
    chk("arst_idle", busy, 0);
    chk("arst_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
